rcv_timer_ctrl: RTL

RCV_TIMER_CTRL -- requirements
Module: rcv_timer_ctrl

---
 rtl/rcv_timer_ctrl.sv | 127 ++++++++++++
 1 files changed

// File: rtl/rcv_timer_ctrl.sv
// Receive-frame bit timer: times start, data and stop bits from a latched
// bit period and emits mid-bit sample strobes plus a frame-done pulse.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | waiting for start_bit_detected; counters held at zero
// START  | timing the start bit, per_q cycles
// SAMPLE | timing data bits; shift_strobe at mid-bit, bit_cnt advances
// STOP   | timing the stop bit; stop_strobe at mid-bit
// DONE   | single cycle with packet_done, then back to IDLE
module rcv_timer_ctrl #(
    parameter int DIV_BITS     = 4,
    parameter int BIT_CNT_BITS = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start_bit_detected,
    input  logic [DIV_BITS-1:0]     bit_period,
    input  logic [BIT_CNT_BITS-1:0] num_bits,
    input  logic                    abort,
    output logic                    shift_strobe,
    output logic                    stop_strobe,
    output logic                    packet_done,
    output logic                    busy,
    output logic [BIT_CNT_BITS-1:0] bit_index
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_SAMPLE = 3'd2;
    localparam logic [2:0] S_STOP   = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    localparam logic [DIV_BITS-1:0]     DIV_ONE = DIV_BITS'(1);
    localparam logic [DIV_BITS-1:0]     DIV_TWO = DIV_BITS'(2);
    localparam logic [BIT_CNT_BITS-1:0] BIT_ONE = BIT_CNT_BITS'(1);

    logic [2:0]              r_state;
    logic [DIV_BITS-1:0]     r_div_cnt;
    logic [DIV_BITS-1:0]     r_per_q;
    logic [BIT_CNT_BITS-1:0] r_bit_cnt;
    logic [BIT_CNT_BITS-1:0] r_nb_q;

    logic                    w_period_end;
    logic                    w_mid_bit;
    logic                    w_last_bit;
    logic [DIV_BITS-1:0]     w_per_lat;
    logic [BIT_CNT_BITS-1:0] w_nb_lat;

    // A period below 2 would leave no room for a distinct mid-bit sample.
    assign w_per_lat    = (bit_period < DIV_TWO) ? DIV_TWO : bit_period;
    assign w_nb_lat     = (num_bits == '0) ? BIT_ONE : num_bits;
    assign w_period_end = (r_div_cnt == (r_per_q - DIV_ONE));
    assign w_mid_bit    = (r_div_cnt == (r_per_q >> 1));
    assign w_last_bit   = (r_bit_cnt == (r_nb_q - BIT_ONE));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_div_cnt <= '0;
            r_bit_cnt <= '0;
            r_per_q   <= '0;
            r_nb_q    <= '0;
        end else if (abort && (r_state != S_IDLE)) begin
            r_state   <= S_IDLE;
            r_div_cnt <= '0;
            r_bit_cnt <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start_bit_detected && !abort) begin
                        r_state   <= S_START;
                        r_div_cnt <= '0;
                        r_bit_cnt <= '0;
                        r_per_q   <= w_per_lat;
                        r_nb_q    <= w_nb_lat;
                    end
                end
                S_START: begin
                    if (w_period_end) begin
                        r_state   <= S_SAMPLE;
                        r_div_cnt <= '0;
                        r_bit_cnt <= '0;
                    end else begin
                        r_div_cnt <= r_div_cnt + DIV_ONE;
                    end
                end
                S_SAMPLE: begin
                    if (w_period_end) begin
                        r_div_cnt <= '0;
                        if (w_last_bit) begin
                            r_state   <= S_STOP;
                            r_bit_cnt <= '0;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + BIT_ONE;
                        end
                    end else begin
                        r_div_cnt <= r_div_cnt + DIV_ONE;
                    end
                end
                S_STOP: begin
                    if (w_period_end) begin
                        r_state   <= S_DONE;
                        r_div_cnt <= '0;
                    end else begin
                        r_div_cnt <= r_div_cnt + DIV_ONE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_div_cnt <= '0;
                    r_bit_cnt <= '0;
                end
            endcase
        end
    end

    assign shift_strobe = (r_state == S_SAMPLE) && w_mid_bit;
    assign stop_strobe  = (r_state == S_STOP) && w_mid_bit;
    assign packet_done  = (r_state == S_DONE);
    assign busy         = (r_state != S_IDLE);
    assign bit_index    = (r_state == S_SAMPLE) ? r_bit_cnt : '0;

endmodule
